// File: rtl/async_req_arbiter_if.sv
// Handshake bundle between the asynchronous requesters / shared resource and the arbiter.
// The arbiter uses the slave modport; requesters and the resource together use master.
`timescale 1ns/1ps
interface async_req_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]  async_req;
  logic [N-1:0]  ack;
  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic          done;
  logic          timeout_err;

  modport master (
    output async_req,
    output done,
    input  ack,
    input  grant_vld,
    input  grant_idx,
    input  timeout_err
  );

  modport slave (
    input  async_req,
    input  done,
    output ack,
    output grant_vld,
    output grant_idx,
    output timeout_err
  );
endinterface

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter for N asynchronous four-phase requesters sharing one synchronous resource.
// Optional ACK-phase timeout with per-channel masking is enabled by defining ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module async_req_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input logic                clk,
  input logic                rst,
  async_req_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(N);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StAck   = 2'd2;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("async_req_arbiter: N must be within 2..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("async_req_arbiter: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("async_req_arbiter: TIMEOUT must be at least 1");
  end

  // Stage 0 is the only flop that sees raw async_req; sreq is the last stage.
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  sreq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.async_req};
    end
  end

  assign sreq = sync_q[SYNC_STAGES-1];

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic          grant_vld_q, grant_vld_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [N-1:0]  eligible;
  logic [N-1:0]  grant_oh;
  logic [IW-1:0] next_ptr;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [N-1:0]  mask_q, mask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  assign eligible = sreq & ~mask_q;
`else
  assign eligible = sreq;
`endif

  assign grant_oh = {{(N-1){1'b0}}, 1'b1} << grant_idx_q;
  assign next_ptr = (32'(grant_idx_q) == N - 1) ? '0 : grant_idx_q + 1'b1;

  // Round-robin scan: first eligible request at or after ptr, wrapping N-1 -> 0.
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  int unsigned   cand_int;

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    cand_int = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand_int = (32'(ptr_q) + k) % N;
      cand     = IW'(cand_int);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    grant_vld_d = grant_vld_q;
    ack_d       = ack_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
    mask_d      = mask_q & sreq;
`endif
    case (state_q)
      StIdle: begin
        if (found) begin
          grant_idx_d = pick;
          grant_vld_d = 1'b1;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        // Served even if the request has already dropped.
        if (bus.done) begin
          grant_vld_d = 1'b0;
          ack_d       = grant_oh;
          state_d     = StAck;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      StAck: begin
        if (!sreq[grant_idx_q]) begin
          ack_d   = '0;
          ptr_d   = next_ptr;
          state_d = StIdle;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Stuck requester: drop it from arbitration until its request falls.
          ack_d               = '0;
          tmo_d               = 1'b1;
          mask_d[grant_idx_q] = 1'b1;
          ptr_d               = next_ptr;
          state_d             = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d     = StIdle;
        grant_vld_d = 1'b0;
        ack_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      grant_vld_q <= 1'b0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_vld_q <= grant_vld_d;
      ack_q       <= ack_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      cnt_q  <= '0;
      tmo_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign bus.timeout_err = tmo_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.ack       = ack_q;
  assign bus.grant_vld = grant_vld_q;
  assign bus.grant_idx = grant_idx_q;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Directed bench for async_req_arbiter; expected grant indices flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_async_req_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned IW = $clog2(N);

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  logic [IW-1:0] sb[$];
  logic [IW-1:0] e;
  int            x_seen;
  int            grants;
  int            ack_bad;
  int            gv_cnt;
  logic          gv_prev;
  logic          seen_gv;

  async_req_arbiter_if #(.N(N)) bus ();

  async_req_arbiter #(
    .N          (N),
    .SYNC_STAGES(SS),
    .TIMEOUT    (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.async_req = '0;
    bus.done      = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Bounded wait for a grant, then compare its index with the scoreboard head.
  task automatic wait_grant(input string tag, output logic [IW-1:0] exp_idx);
    int n;
    n       = 0;
    exp_idx = '0;
    while (bus.grant_vld !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    chk({tag, " grant seen"}, 32'(bus.grant_vld), 32'd1);
    if (sb.size() != 0) exp_idx = sb.pop_front();
    else chk({tag, " scoreboard empty"}, 32'(sb.size()), 32'd1);
    chk({tag, " idx"}, 32'(bus.grant_idx), 32'(exp_idx));
  endtask

  // Resource completes, requester sees ack and drops its line, optionally re-raising it.
  task automatic finish_grant(input string tag, input logic [IW-1:0] idx, input bit reraise);
    logic [N-1:0] oh;
    int n;
    oh       = N'(1) << idx;
    bus.done = 1'b1;
    step(1);
    bus.done = 1'b0;
    chk({tag, " ack"}, 32'(bus.ack), 32'(oh));
    chk({tag, " gv low in ack"}, 32'(bus.grant_vld), 32'd0);
    bus.async_req = bus.async_req & ~oh;
    n = 0;
    while (bus.ack !== '0 && n < 20) begin
      step(1);
      n++;
    end
    chk({tag, " ack release"}, 32'(bus.ack), 32'd0);
    if (reraise) bus.async_req = bus.async_req | oh;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b0;
    bus.async_req = '0;
    bus.done      = 1'b0;
    x_seen        = 0;
    grants        = 0;
    ack_bad       = 0;
    gv_cnt        = 0;
    gv_prev       = 1'b0;
    seen_gv       = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("reset ack", 32'(bus.ack), 32'd0);
    chk("reset gv", 32'(bus.grant_vld), 32'd0);
    chk("reset idx", 32'(bus.grant_idx), 32'd0);
    chk("reset terr", 32'(bus.timeout_err), 32'd0);
    step(2);
    rst = 1'b0;
    step(1);

    // Single request: latency SYNC_STAGES+1 edges, ack release SYNC_STAGES+1 edges
    @(posedge clk);
    #3;
    bus.async_req[2] = 1'b1;
    sb.push_back(IW'(2));
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("single gv before edge 3", 32'(bus.grant_vld), 32'd0);
    step(1);
    chk("single gv edge 3", 32'(bus.grant_vld), 32'd1);
    wait_grant("single", e);
    bus.done = 1'b1;
    step(1);
    bus.done = 1'b0;
    chk("single ack", 32'(bus.ack), 32'h4);
    chk("single gv cleared", 32'(bus.grant_vld), 32'd0);
    #2;
    bus.async_req[2] = 1'b0;
    step(2);
    chk("single ack hold", 32'(bus.ack), 32'h4);
    step(1);
    chk("single ack drop", 32'(bus.ack), 32'd0);

    // Fairness: 4'b1011 held, each requester re-raises after its ack
    do_reset();
    sb.push_back(IW'(0)); sb.push_back(IW'(1)); sb.push_back(IW'(3));
    sb.push_back(IW'(0)); sb.push_back(IW'(1)); sb.push_back(IW'(3));
    bus.async_req = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      wait_grant($sformatf("fair%0d", i), e);
      finish_grant($sformatf("fair%0d", i), e, 1'b1);
    end

    // Mid-cycle toggling of async_req[0]
    do_reset();
    @(posedge clk);
    fork
      begin
        #7 bus.async_req[0] = 1'b1;
        #7 bus.async_req[0] = 1'b0;
        #3 bus.async_req[0] = 1'b1;
        #9 bus.async_req[0] = 1'b0;
      end
      begin
        for (int c = 0; c < 25; c++) begin
          @(posedge clk);
          #1;
          if ($isunknown({bus.ack, bus.grant_vld, bus.grant_idx, bus.timeout_err})) x_seen++;
          if (bus.grant_vld && !gv_prev) grants++;
          if (bus.grant_vld) seen_gv = 1'b1;
          if (bus.ack != '0 && !seen_gv) ack_bad++;
          gv_prev  = bus.grant_vld;
          bus.done = bus.grant_vld;
        end
      end
    join
    bus.done = 1'b0;
    chk("toggle no X", 32'(x_seen), 32'd0);
    chk("toggle at most one grant", 32'(grants <= 1), 32'd1);
    chk("toggle ack after grant", 32'(ack_bad), 32'd0);
    chk("toggle idle ack", 32'(bus.ack), 32'd0);

    // Reset mid-GRANT
    do_reset();
    bus.async_req[1] = 1'b1;
    sb.push_back(IW'(1));
    wait_grant("rst pre", e);
    #2 rst = 1'b1;
    #1;
    chk("rst mid ack", 32'(bus.ack), 32'd0);
    chk("rst mid gv", 32'(bus.grant_vld), 32'd0);
    chk("rst mid idx", 32'(bus.grant_idx), 32'd0);
    bus.async_req = 4'b1000;
    #1 rst = 1'b0;
    sb.push_back(IW'(3));
    step(2);
    chk("rst post gv early", 32'(bus.grant_vld), 32'd0);
    step(1);
    chk("rst post gv edge 3", 32'(bus.grant_vld), 32'd1);
    wait_grant("rst post", e);
    finish_grant("rst post", e, 1'b0);

    // Stray done in IDLE
    do_reset();
    bus.done = 1'b1;
    step(1);
    bus.done = 1'b0;
    chk("stray gv", 32'(bus.grant_vld), 32'd0);
    chk("stray ack", 32'(bus.ack), 32'd0);
    step(3);
    chk("stray gv later", 32'(bus.grant_vld), 32'd0);
    chk("stray ack later", 32'(bus.ack), 32'd0);
    chk("stray terr", 32'(bus.timeout_err), 32'd0);
    bus.async_req[0] = 1'b1;
    sb.push_back(IW'(0));
    wait_grant("stray after", e);
    finish_grant("stray after", e, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // ACK-phase timeout with masking of the stuck requester
    do_reset();
    sb.push_back(IW'(1));
    sb.push_back(IW'(2));
    bus.async_req = 4'b0110;
    wait_grant("tmo", e);
    bus.done = 1'b1;
    step(1);
    bus.done = 1'b0;
    chk("tmo ack", 32'(bus.ack), 32'h2);
    step(7);
    chk("tmo ack hold", 32'(bus.ack), 32'h2);
    chk("tmo terr early", 32'(bus.timeout_err), 32'd0);
    step(1);
    chk("tmo ack cleared", 32'(bus.ack), 32'd0);
    chk("tmo terr pulse", 32'(bus.timeout_err), 32'd1);
    step(1);
    chk("tmo terr one cycle", 32'(bus.timeout_err), 32'd0);
    wait_grant("tmo next", e);
    finish_grant("tmo next", e, 1'b0);
    gv_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (bus.grant_vld) gv_cnt++;
    end
    chk("tmo masked no grant", 32'(gv_cnt), 32'd0);
    bus.async_req[1] = 1'b0;
    step(4);
    bus.async_req[1] = 1'b1;
    sb.push_back(IW'(1));
    wait_grant("tmo unmasked", e);
    finish_grant("tmo unmasked", e, 1'b0);
`endif

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/async_req_arbiter.md
# async_req_arbiter

Round-robin arbiter that lets N asynchronous requesters share one synchronous resource through a four-phase req/ack handshake. Each asynchronous request line passes through its own multi-stage synchronizer before the arbiter sees it. The winning requester's index is presented to the resource, and the arbiter waits for the resource's completion. It then drives ack back to the requester and waits for the synchronized request to fall before re-arbitrating. The block sits at the clock-domain boundary, directly behind the design's async inputs.

## Interface
- N, 4: number of requesters, 2..16.
- SYNC_STAGES, 2: synchronizer flops per request line, at least 2.
- TIMEOUT, 64: ACK-phase timeout in cycles. Used only when ARB_TIMEOUT_EN is defined.
- IW, $clog2(N): width of the index (derived localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- async_req  in  N  asynchronous request lines, one per requester, level-sensitive.
- ack  out  N  registered acknowledge, one per requester, one-hot or zero.
- grant_vld  out  1  resource is granted to grant_idx.
- grant_idx  out  IW  index of the current grantee.
- done  in  1  one-cycle pulse from the resource marking the end of service.
- timeout_err  out  1  one-cycle pulse when an ACK phase times out.

## Operation
- Synchronizer: each async_req bit feeds a SYNC_STAGES-deep flop chain. Only the last stage, sreq[i], is used anywhere else. Raw async_req never reaches logic.
- State machine has three states:
  - IDLE: if any unmasked sreq bit is high, pick the first one at or after ptr, scanning upward with wrap from N-1 to 0. Register it as grant_idx and go to GRANT.
  - GRANT: grant_vld=1. On done=1, go to ACK and set ack[grant_idx]=1.
  - ACK: hold ack[grant_idx]=1. When sreq[grant_idx]=0, clear ack, set ptr=(grant_idx+1) mod N and go to IDLE.
- done is ignored outside GRANT.
- A requester that drops its request during GRANT is still served. The ACK phase then ends as soon as sreq is observed low.
- Simultaneous requests: the requester nearest ptr wins. The others stay pending and are never lost, because requests are levels.
- ptr changes only when an ACK phase completes, so every pending requester is granted within N grant cycles.
- rst, at any time including mid-GRANT or mid-ACK, immediately sets:
  - state=IDLE, ptr=0, ack=0, grant_vld=0, grant_idx=0, timeout_err=0;
  - all synchronizer flops and mask bits to 0.

## Timing
- Latency from async_req rising to grant_vld: SYNC_STAGES+1 rising edges. The first edge counted is the first edge that samples async_req=1.
- done=1 at edge k: grant_vld=0 and ack=1 after edge k.
- sreq falls at edge m: ack=0 after edge m+1. The next grant_vld appears after edge m+2 at the earliest.
- ack is asserted only for the index held in grant_idx. At most one ack bit is high at any time.
- Request pulses shorter than one clock period may be missed. Requesters must hold req until they see ack.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter runs while in ACK. If sreq[grant_idx] is still high after TIMEOUT cycles:
    - clear ack and pulse timeout_err for one cycle;
    - set mask[grant_idx]=1, advance ptr and return to IDLE.
  - mask[i] clears when sreq[i] is observed low. Masked channels are excluded from arbitration.
- ARB_TIMEOUT_EN undefined:
  - No counter and no mask. ACK waits indefinitely.
  - timeout_err is tied to 0.

## Test plan
- Single request: N=4, SYNC_STAGES=2. Raise async_req[2] 3 ns after an edge. Required: grant_vld=1 and grant_idx=2 after the 3rd edge. Pulse done, then expect ack[2]=1 next cycle. Drop req, then expect ack[2]=0 exactly SYNC_STAGES+1 edges later.
- Fairness: hold async_req=4'b1011 and answer every grant with done, and every ack by dropping then re-raising the request. Required grant order: 0, 1, 3, 0, 1, 3.
- Mid-cycle toggling: drive async_req[0] as 0→1 at 12 ns, →0 at 19 ns, →1 at 22 ns, →0 at 31 ns, with a 10 ns clock. Required: no X on any output, at most one grant issued, ack never high without a preceding grant_vld.
- Reset mid-operation: assert rst while in GRANT for index 1. Required: ack=0, grant_vld=0, grant_idx=0 immediately, with no clock needed. After release with async_req[3] high, the first grant goes to index 3 at SYNC_STAGES+1 edges.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): never drop async_req[1] after ack. Required: ack[1]=0 and a one-cycle timeout_err pulse 8 cycles into ACK. Index 1 receives no grant until its request drops; pending index 2 is granted next.
- Stray done: pulse done while in IDLE with no requests. Required: no state change, ack and grant_vld stay 0.
